// File: rtl/mario_pkg.sv
// Shared types and constants for the player motion block.
// Key codes are USB HID usage IDs.
package mario_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    JUMP   = 2'd1,
    FALL   = 2'd2
  } motion_state_t;

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPRITE_W = 16;
  localparam int SPRITE_H = 16;

  // True when any of the four key slots holds the given code.
  function automatic logic key_hit(
    input logic [31:0] kc,
    input logic [7:0]  k
  );
    return (kc[7:0]   == k) |
           (kc[15:8]  == k) |
           (kc[23:16] == k) |
           (kc[31:24] == k);
  endfunction

endpackage

// File: rtl/mario_motion_key_decode.sv
// Keycode decoder: left/right levels and a jump
// rising-edge pulse (a held jump key fires once).
module key_decode (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_keycode,
  output logic        o_left,
  output logic        o_right,
  output logic        o_jump_press
);
  import mario_pkg::*;

  logic w_jump_key;
  logic r_jump_prev;

  assign o_left  = key_hit(i_keycode, KEY_A);
  assign o_right = key_hit(i_keycode, KEY_D);

  assign w_jump_key = key_hit(i_keycode, KEY_W) |
                      key_hit(i_keycode, KEY_SPACE);

  assign o_jump_press = w_jump_key & ~r_jump_prev;

  // Remember last frame's jump key for edge detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_jump_prev <= 1'b0;
    else       r_jump_prev <= w_jump_key;
  end

endmodule

// File: rtl/mario_motion.sv
// Per-frame sprite physics: walk, jump profile, gravity.
// Optional macro RUN_ACCEL_EN enables run acceleration.
module mario_motion #(
  parameter logic [9:0] X_START    = 10'd80,
  parameter logic [9:0] FLOOR_Y    = 10'd400,
  parameter logic [9:0] X_MIN      = 10'd0,
  parameter logic [9:0] X_MAX      = 10'd623,
  parameter logic [9:0] Y_MIN      = 10'd0,
  parameter logic [9:0] WALK_SPEED = 10'd2,
  parameter logic [9:0] GRAVITY    = 10'd1,
  parameter logic [9:0] MAX_FALL   = 10'd8
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [31:0] keycode,
  input  logic [9:0]  jump_x_motion,
  input  logic [9:0]  jump_y_motion,
  output logic        jump_en,
  output logic        hit_ground,
  output logic [9:0]  mario_x,
  output logic [9:0]  mario_y,
  output logic        facing_left
);
  import mario_pkg::*;

  localparam logic signed [11:0] C_WALK =
    $signed({2'b00, WALK_SPEED});
  localparam logic signed [11:0] C_XMIN =
    $signed({2'b00, X_MIN});
  localparam logic signed [11:0] C_XMAX =
    $signed({2'b00, X_MAX});
  localparam logic signed [11:0] C_YMIN =
    $signed({2'b00, Y_MIN});

  logic                w_left;
  logic                w_right;
  logic                w_jump_press;
  logic                w_left_only;
  logic                w_right_only;

  motion_state_t       r_state;
  motion_state_t       w_state_nxt;
  logic [9:0]          r_vy;
  logic [9:0]          w_vy_nxt;
  logic [9:0]          w_vy_acc;
  logic [10:0]         w_vy_sum;
  logic [10:0]         w_fall_sum;
  logic [1:0]          r_jf;
  logic [1:0]          w_jf_nxt;
  logic [9:0]          w_x_nxt;
  logic [9:0]          w_y_nxt;
  logic                w_jump_en_nxt;
  logic                w_facing_nxt;

  logic signed [11:0]  w_jx;
  logic signed [11:0]  w_jy;
  logic signed [11:0]  w_jx_eff;
  logic signed [11:0]  w_vx_nxt;
  logic signed [11:0]  w_x_sum;
  logic signed [11:0]  w_y_sum;

  key_decode u_keys (
    .i_clk        (frame_clk),
    .i_rst        (Reset),
    .i_keycode    (keycode),
    .o_left       (w_left),
    .o_right      (w_right),
    .o_jump_press (w_jump_press)
  );

  assign w_left_only  = w_left & ~w_right;
  assign w_right_only = w_right & ~w_left;

  assign w_jx = {{2{jump_x_motion[9]}}, jump_x_motion};
  assign w_jy = {{2{jump_y_motion[9]}}, jump_y_motion};

`ifdef RUN_ACCEL_EN
  localparam logic signed [11:0] C_RUN = C_WALK <<< 1;

  logic signed [11:0] r_vx;
  logic signed [11:0] w_vx_tgt;

  // Step velocity by one toward the held direction's run speed.
  always_comb begin
    w_vx_tgt = 12'sd0;
    if (w_left_only)       w_vx_tgt = -C_RUN;
    else if (w_right_only) w_vx_tgt = C_RUN;
    w_vx_nxt = r_vx;
    if (r_vx < w_vx_tgt)      w_vx_nxt = r_vx + 12'sd1;
    else if (r_vx > w_vx_tgt) w_vx_nxt = r_vx - 12'sd1;
  end

  // Horizontal velocity register.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) r_vx <= 12'sd0;
    else       r_vx <= w_vx_nxt;
  end
`else
  // Fixed walk speed while exactly one direction is held.
  always_comb begin
    w_vx_nxt = 12'sd0;
    if (w_left_only)       w_vx_nxt = -C_WALK;
    else if (w_right_only) w_vx_nxt = C_WALK;
  end
`endif

  assign w_jx_eff = (r_state == JUMP) ? w_jx : 12'sd0;
  assign w_x_sum  = $signed({2'b00, r_x_q()}) + w_vx_nxt + w_jx_eff;

  function automatic logic [9:0] r_x_q();
    return mario_x;
  endfunction

  // Clamp horizontal position; negative sums never wrap.
  always_comb begin
    w_x_nxt = w_x_sum[9:0];
    if (w_x_sum < C_XMIN)      w_x_nxt = X_MIN;
    else if (w_x_sum > C_XMAX) w_x_nxt = X_MAX;
  end

  // Facing follows the last single-direction input.
  always_comb begin
    w_facing_nxt = facing_left;
    if (w_left_only)       w_facing_nxt = 1'b1;
    else if (w_right_only) w_facing_nxt = 1'b0;
  end

  assign w_y_sum    = $signed({2'b00, mario_y}) + w_jy;
  assign w_vy_sum   = {1'b0, r_vy} + {1'b0, GRAVITY};
  assign w_vy_acc   = (w_vy_sum > {1'b0, MAX_FALL}) ?
                      MAX_FALL : w_vy_sum[9:0];
  assign w_fall_sum = {1'b0, mario_y} + {1'b0, w_vy_acc};

  // Vertical state machine: ground, profile rise, gravity fall.
  always_comb begin
    w_state_nxt   = r_state;
    w_y_nxt       = mario_y;
    w_vy_nxt      = r_vy;
    w_jf_nxt      = r_jf;
    w_jump_en_nxt = 1'b0;
    unique case (r_state)
      GROUND: begin
        if (w_jump_press) begin
          w_state_nxt   = JUMP;
          w_jf_nxt      = 2'd0;
          w_jump_en_nxt = 1'b1;
        end
      end
      JUMP: begin
        if (w_y_sum < C_YMIN) begin
          w_y_nxt     = Y_MIN;
          w_vy_nxt    = 10'd0;
          w_state_nxt = FALL;
        end else begin
          w_y_nxt = w_y_sum[9:0];
          if (jump_y_motion == 10'd0 && r_jf >= 2'd2) begin
            w_vy_nxt    = 10'd0;
            w_state_nxt = FALL;
          end else if (r_jf != 2'd3) begin
            w_jf_nxt = r_jf + 2'd1;
          end
        end
      end
      FALL: begin
        if (w_fall_sum >= {1'b0, FLOOR_Y}) begin
          w_y_nxt     = FLOOR_Y;
          w_vy_nxt    = 10'd0;
          w_state_nxt = GROUND;
        end else begin
          w_y_nxt  = w_fall_sum[9:0];
          w_vy_nxt = w_vy_acc;
        end
      end
      default: begin
        w_state_nxt = GROUND;
        w_y_nxt     = FLOOR_Y;
        w_vy_nxt    = 10'd0;
      end
    endcase
  end

  // Frame update of all state and registered outputs.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= GROUND;
      r_vy        <= 10'd0;
      r_jf        <= 2'd0;
      mario_x     <= X_START;
      mario_y     <= FLOOR_Y;
      jump_en     <= 1'b0;
      hit_ground  <= 1'b1;
      facing_left <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_vy        <= w_vy_nxt;
      r_jf        <= w_jf_nxt;
      mario_x     <= w_x_nxt;
      mario_y     <= w_y_nxt;
      jump_en     <= w_jump_en_nxt;
      hit_ground  <= (w_state_nxt == GROUND);
      facing_left <= w_facing_nxt;
    end
  end

endmodule

// File: tb/tb_mario_motion.sv
// Scoreboard bench for mario_motion with a
// behavioural physics model and a jump-profile source.
module tb_mario_motion;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [31:0] keycode;
  logic [9:0]  jump_x_motion;
  logic [9:0]  jump_y_motion;
  logic        jump_en;
  logic        hit_ground;
  logic [9:0]  mario_x;
  logic [9:0]  mario_y;
  logic        facing_left;

  mario_motion dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .keycode       (keycode),
    .jump_x_motion (jump_x_motion),
    .jump_y_motion (jump_y_motion),
    .jump_en       (jump_en),
    .hit_ground    (hit_ground),
    .mario_x       (mario_x),
    .mario_y       (mario_y),
    .facing_left   (facing_left)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    int je;
    int hg;
    int x;
    int y;
    int fl;
  } exp_t;

  typedef struct {
    int jx;
    int jy;
  } pf_t;

  exp_t q[$];
  pf_t  pq[$];

  int checks = 0;
  int errors = 0;
  int je_cnt;
  int min_y;
  int max_y;
  int prof_kind;

  localparam int SG = 0;
  localparam int SJ = 1;
  localparam int SF = 2;

  int m_st, m_x, m_y, m_vx, m_vy, m_jf, m_fl;
  bit m_prev;

  int std_prof[18] = '{-12, -12, -12, -12, -10, -10, -10, -10,
                       -8, -8, -6, -6, -4, -4, -2, -2, -2, -2};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_st = SG; m_x = 80; m_y = 400; m_vx = 0;
    m_vy = 0; m_jf = 0; m_fl = 0; m_prev = 0;
  endfunction

  function automatic void load_profile();
    int n;
    pq.delete();
    pq.push_back('{0, 0});
    case (prof_kind)
      0: foreach (std_prof[i]) pq.push_back('{0, std_prof[i]});
      2: repeat (8) pq.push_back('{0, -60});
      3: repeat (4) pq.push_back('{0, -25});
      default: begin
        n = $urandom_range(2, 12);
        repeat (n)
          pq.push_back('{$urandom_range(0, 10) - 5,
                         -$urandom_range(1, 20)});
      end
    endcase
  endfunction

  function automatic void model(input logic [31:0] kc,
                                input int jx, input int jy);
    bit l, r, jk, press;
    int dir, xs, ys, je;
    logic [7:0] by;
    l = 0; r = 0; jk = 0;
    for (int b = 0; b < 4; b++) begin
      by = kc[8*b +: 8];
      if (by == 8'h04) l = 1;
      if (by == 8'h07) r = 1;
      if (by == 8'h1A || by == 8'h2C) jk = 1;
    end
    press = jk && !m_prev;
    m_prev = jk;
    dir = (l && !r) ? -1 : ((r && !l) ? 1 : 0);
`ifdef RUN_ACCEL_EN
    if (m_vx < 4 * dir) m_vx++;
    else if (m_vx > 4 * dir) m_vx--;
`else
    m_vx = 2 * dir;
`endif
    xs = m_x + m_vx + ((m_st == SJ) ? jx : 0);
    if (xs < 0) xs = 0;
    if (xs > 623) xs = 623;
    if (dir == -1) m_fl = 1;
    if (dir == 1) m_fl = 0;
    je = 0;
    case (m_st)
      SG: if (press) begin m_st = SJ; m_jf = 0; je = 1; end
      SJ: begin
        ys = m_y + jy;
        if (ys < 0) begin
          m_y = 0; m_vy = 0; m_st = SF;
        end else begin
          m_y = ys;
          if (jy == 0 && m_jf >= 2) begin m_vy = 0; m_st = SF; end
          else m_jf++;
        end
      end
      default: begin
        m_vy = (m_vy + 1 > 8) ? 8 : m_vy + 1;
        if (m_y + m_vy >= 400) begin
          m_y = 400; m_vy = 0; m_st = SG;
        end else m_y = m_y + m_vy;
      end
    endcase
    m_x = xs;
    if (je == 1) load_profile();
    q.push_back('{je, (m_st == SG), m_x, m_y, m_fl});
  endfunction

  task automatic step(input logic [31:0] kc);
    pf_t pf;
    @(negedge frame_clk);
    pf = '{0, 0};
    if (pq.size() > 0) pf = pq.pop_front();
    keycode = kc;
    jump_x_motion = 10'(pf.jx);
    jump_y_motion = 10'(pf.jy);
    model(kc, pf.jx, pf.jy);
  endtask

  function automatic logic [31:0] rand_kc();
    logic [31:0] kc;
    logic [7:0] by;
    for (int b = 0; b < 4; b++) begin
      case ($urandom_range(0, 9))
        4: by = 8'h04;
        5: by = 8'h07;
        6: by = 8'h1A;
        7: by = 8'h2C;
        8: by = 8'($urandom_range(0, 255));
        default: by = 8'h00;
      endcase
      kc[8*b +: 8] = by;
    end
    return kc;
  endfunction

  // Monitor: pop expected frame results and compare.
  always @(posedge frame_clk) begin
    exp_t e;
    #1;
    if (!Reset) begin
      je_cnt += int'(jump_en);
      if (int'(mario_y) < min_y) min_y = int'(mario_y);
      if (int'(mario_y) > max_y) max_y = int'(mario_y);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("jump_en", 32'(jump_en), 32'(e.je));
        chk("hit_ground", 32'(hit_ground), 32'(e.hg));
        chk("mario_x", 32'(mario_x), 32'(e.x));
        chk("mario_y", 32'(mario_y), 32'(e.y));
        chk("facing_left", 32'(facing_left), 32'(e.fl));
      end
    end
  end

  initial begin
    int sum;
    int x0;
    int n;
    Reset = 1'b1;
    keycode = 32'h0;
    jump_x_motion = 10'd0;
    jump_y_motion = 10'd0;
    je_cnt = 0; min_y = 400; max_y = 0;
    prof_kind = 0;
    model_reset();
    repeat (2) @(posedge frame_clk);
    #2;
    chk("rst_x", 32'(mario_x), 32'd80);
    chk("rst_y", 32'(mario_y), 32'd400);
    chk("rst_hg", 32'(hit_ground), 32'd1);
    chk("rst_je", 32'(jump_en), 32'd0);
    chk("rst_fl", 32'(facing_left), 32'd0);
    @(negedge frame_clk);
    Reset = 1'b0;

    // Held W: one jump with the standard profile.
    je_cnt = 0; min_y = 400; max_y = 0;
    sum = 0;
    foreach (std_prof[i]) sum += std_prof[i];
    repeat (60) step(32'h0000001A);
    @(posedge frame_clk); #2;
    chk("held_jump_once", 32'(je_cnt), 32'd1);
    chk("peak_y", 32'(min_y), 32'(400 + sum));
    chk("max_y", 32'(max_y), 32'd400);
    chk("landed", 32'(hit_ground), 32'd1);
    repeat (3) step(32'h0);

    // Fall from y=300 with terminal velocity.
    prof_kind = 3; min_y = 400; max_y = 0;
    step(32'h0000001A);
    repeat (40) step(32'h0);
    @(posedge frame_clk); #2;
    chk("fall_top", 32'(min_y), 32'd300);
    chk("fall_floor", 32'(max_y), 32'd400);

    // Reset while falling.
    step(32'h00002C00);
    n = 0;
    while (!(m_st == SF && m_y >= 310) && n < 40) begin
      step(32'h0);
      n++;
    end
    chk("reached_fall", 32'(n < 40), 32'd1);
    @(negedge frame_clk); #2;
    keycode = 32'h0;
    Reset = 1'b1;
    q.delete();
    pq.delete();
    #1;
    chk("midrst_x", 32'(mario_x), 32'd80);
    chk("midrst_y", 32'(mario_y), 32'd400);
    chk("midrst_hg", 32'(hit_ground), 32'd1);
    chk("midrst_je", 32'(jump_en), 32'd0);
    @(posedge frame_clk);
    @(negedge frame_clk);
    Reset = 1'b0;
    model_reset();

    // Horizontal clamps and conflicting keys.
    repeat (300) step(32'h00000007);
    @(posedge frame_clk); #2;
    chk("x_max", 32'(mario_x), 32'd623);
    repeat (320) step(32'h04000000);
    @(posedge frame_clk); #2;
    chk("x_min", 32'(mario_x), 32'd0);
    chk("face_l", 32'(facing_left), 32'd1);
    repeat (5) step(32'h00000007);
    x0 = m_x;
    repeat (5) step(32'h00000704);
    @(posedge frame_clk); #2;
`ifndef RUN_ACCEL_EN
    chk("both_keys", 32'(mario_x), 32'(x0));
`endif
    chk("face_hold", 32'(facing_left), 32'd0);

    // Acceleration / release profile.
    repeat (10) step(32'h00000007);
    repeat (6) step(32'h0);
    repeat (4) step(32'h00000004);
    repeat (6) step(32'h00000007);

    // Randomized traffic with random and head-bump profiles.
    repeat (600) begin
      prof_kind = ($urandom_range(0, 4) == 0) ? 2 : 1;
      step(rand_kc());
    end
    repeat (60) step(32'h0);

    repeat (2) @(posedge frame_clk);
    #2;
    chk("drain", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
